// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency single-line memory responder.
// One request is accepted from IDLE; after LATENCY cycles a one-cycle
// pmem_resp pulse completes it. Writes commit on the edge that ends the
// response cycle. The optional protocol checker is built only when the
// macro PMEM_PROTOCOL_CHECK_EN is defined; otherwise proto_err is tied 0.
module pmem_responder #(
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned IDX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with LATENCY-1 on acceptance and reaches 0 on the
    // edge that enters RESP, so the response lands exactly LATENCY cycles
    // after the request first appears.
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam bit         SKIP_BUSY = (LATENCY == 1);
    localparam int unsigned LINES    = 1 << IDX_BITS;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [255:0]          wdata_q, wdata_d;
    logic [255:0]          rdata_q;
    logic [255:0]          mem [LINES];

    logic [IDX_BITS-1:0]   addr_idx;
    logic [IDX_BITS-1:0]   rd_idx;
    logic                  req;

    assign addr_idx = pmem_address[IDX_BITS+4:5];
    assign req      = pmem_read | pmem_write;
    // With LATENCY=1 the read happens on the accepting edge, before idx_q
    // holds the new index, so take it straight from the address.
    assign rd_idx   = (state_q == IDLE) ? addr_idx : idx_q;

    // Next-state logic: accept in IDLE, count down in BUSY, pulse in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = addr_idx;
                    wr_d    = pmem_write;   // write wins when both are high
                    wdata_d = pmem_wdata;
                    if (SKIP_BUSY) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request fields; no reset needed, only consumed after acceptance.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    // Read data is registered on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rst && state_d == RESP) begin
            rdata_q <= mem[rd_idx];
        end
    end

    // Line storage: write commits as RESP ends; a reset aborts the commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign pmem_resp  = (state_q == RESP);
    assign pmem_rdata = rdata_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [31:0] addr_q;
    logic        after_resp_q;
    logic        err_q;
    logic        viol;

    // Full address is kept so any change mid-operation is caught, even in
    // bits that do not select the line.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            addr_q <= pmem_address;
        end
    end

    // Remember that the previous cycle was the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            after_resp_q <= 1'b0;
        end else begin
            after_resp_q <= (state_q == RESP);
        end
    end

    always_comb begin
        viol = 1'b0;
        if (state_q == BUSY) begin
            if (pmem_address != addr_q)           viol = 1'b1;
            if (pmem_write != wr_q)               viol = 1'b1;
            if (pmem_read != !wr_q)               viol = 1'b1;
            if (wr_q && (pmem_wdata != wdata_q))  viol = 1'b1;
        end
        if (pmem_read && pmem_write)              viol = 1'b1;
        if (after_resp_q && req)                  viol = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:IDX_BITS+5], pmem_address[4:0]};
    assign proto_err = 1'b0;
`endif

endmodule
